// File: rtl/ram_bus_adapter.sv
// Bridge from the 32-bit CPU bus to a single-beat MEM_W-wide memory controller.
// Splits wide accesses into beats, narrows byte/halfword lanes, and handles partial writes.
module ram_bus_adapter #(
  parameter int ADDR_W   = 25,
  parameter int MEM_W    = 16,
  parameter bit USE_MASK = 1'b1,
  localparam int B       = MEM_W / 8,
  localparam int L       = $clog2(B)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              wt,
  output logic              err,
  output logic              cntl_rd,
  output logic              cntl_wr,
  input  logic              cntl_done,
  output logic [ADDR_W-L-1:0] cntl_addr,
  output logic [MEM_W-1:0]  cntl_din,
  input  logic [MEM_W-1:0]  cntl_dout,
  output logic [B-1:0]      cntl_mask,
  output logic [2:0]        dbg_state
);

  // Handshakes: the bus holds en, wr, size, addr and data_in until the single cycle
  // wt is low. Toward the controller, cntl_rd/cntl_wr are valid and stay up (with a
  // stable cntl_addr) until cntl_done, a one-cycle pulse that completes the beat.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [2:0] B3     = 3'(B);
  localparam logic [2:0] N_WORD = 3'(32 / MEM_W);
  localparam logic [2:0] N_HALF = (MEM_W >= 16) ? 3'd1 : 3'd2;

  state_t            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [31:0]       data_out_q, data_out_d;
  logic [MEM_W-1:0]  merge_q, merge_d;
  logic              wt_q, wt_d;
  logic              err_q, err_d;

  logic [2:0]        acc_bytes, n_beats, off, beat_end;
  logic [5:0]        lane_sh, full_sh;
  logic              narrow, misaligned, last_beat;
  logic [31:0]       acc_mask, lane_rd;
  logic [MEM_W-1:0]  lane_bits, lane_wd, full_wd;
  logic [32+MEM_W-1:0] shift_in;

  // Lane geometry is big-endian: byte offset 0 sits in the most significant lane.
  always_comb begin
    acc_bytes  = size[1] ? 3'd4 : (size[0] ? 3'd2 : 3'd1);
    acc_mask   = size[1] ? 32'hffff_ffff : (size[0] ? 32'h0000_ffff : 32'h0000_00ff);
    n_beats    = size[1] ? N_WORD : (size[0] ? N_HALF : 3'd1);
    misaligned = size[1] ? (addr[1:0] != 2'b00) : (size[0] & addr[0]);
    narrow     = acc_bytes < B3;
    off        = {1'b0, addr[1:0]} & (B3 - 3'd1);
    lane_sh    = {B3 - off - acc_bytes, 3'b000};
    beat_end   = B3 * ({1'b0, beat_q} + 3'd1);
    full_sh    = {acc_bytes - beat_end, 3'b000};
    last_beat  = (({1'b0, beat_q} + 3'd1) == n_beats);
    lane_bits  = MEM_W'(acc_mask) << lane_sh;
    lane_wd    = (MEM_W'(data_in) & MEM_W'(acc_mask)) << lane_sh;
    full_wd    = MEM_W'(data_in >> full_sh);
    lane_rd    = 32'(cntl_dout >> lane_sh) & acc_mask;
    shift_in   = {data_out_q, cntl_dout};
  end

  always_comb begin
    cntl_din  = full_wd;
    cntl_mask = '1;
    if (narrow) begin
      if (USE_MASK) begin
        cntl_din = lane_wd;
        for (int j = 0; j < B; j++) cntl_mask[j] = lane_bits[8*j];
      end else begin
        cntl_din = (merge_q & ~lane_bits) | lane_wd;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    data_out_d = data_out_q;
    merge_d    = merge_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        beat_d = 2'd0;
        if (en) begin
          if (misaligned) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (!wr) begin
            state_d    = RD;
            data_out_d = '0;
          end else if (narrow && !USE_MASK) begin
            state_d = RMW_RD;
          end else begin
            state_d = WR;
          end
        end
      end
      RD: begin
        if (cntl_done) begin
          // Beats arrive most significant first, so wide reads shift in from the right.
          data_out_d = narrow ? lane_rd : shift_in[31:0];
          if (last_beat) state_d = DONE;
          else           beat_d  = beat_q + 2'd1;
        end
      end
      RMW_RD: begin
        if (cntl_done) begin
          merge_d = cntl_dout;
          state_d = WR;
        end
      end
      WR: begin
        if (cntl_done) begin
          if (last_beat) state_d = DONE;
          else           beat_d  = beat_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    wt_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_q     <= 2'd0;
      data_out_q <= '0;
      merge_q    <= '0;
      wt_q       <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      data_out_q <= data_out_d;
      merge_q    <= merge_d;
      wt_q       <= wt_d;
      err_q      <= err_d;
    end
  end

  assign cntl_rd   = ((state_q == RD) || (state_q == RMW_RD)) && !cntl_done;
  assign cntl_wr   = (state_q == WR) && !cntl_done;
  assign cntl_addr = addr[ADDR_W-1:L] + (ADDR_W-L)'(beat_q);
  assign data_out  = data_out_q;
  assign wt        = wt_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_bus_adapter.sv
// Directed bench for ram_bus_adapter: three instances (16-bit masked, 16-bit RMW,
// 32-bit masked) driven through a hand-played controller with hand-computed expectations.
module tb_ram_bus_adapter;

  logic        clk = 1'b0;
  logic        reset;
  logic        en [3];
  logic        wr;
  logic [1:0]  size;
  logic [24:0] addr;
  logic [31:0] data_in;
  logic        cdone [3];
  logic [31:0] crdata [3];

  logic [31:0] dout_v [3];
  logic        wt_v [3];
  logic        err_v [3];
  logic        req_rd [3];
  logic        req_wr [3];
  logic [2:0]  st_v [3];
  logic [23:0] ca16m, ca16r;
  logic [22:0] ca32;
  logic [15:0] din16m, din16r;
  logic [31:0] din32;
  logic [1:0]  mk16m, mk16r;
  logic [3:0]  mk32;
  logic [23:0] req_addr [3];
  logic [31:0] req_din [3];
  logic [3:0]  req_mask [3];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  ram_bus_adapter #(.ADDR_W(25), .MEM_W(16), .USE_MASK(1'b1)) u16m (
    .clk(clk), .reset(reset), .en(en[0]), .wr(wr), .size(size), .addr(addr),
    .data_in(data_in), .data_out(dout_v[0]), .wt(wt_v[0]), .err(err_v[0]),
    .cntl_rd(req_rd[0]), .cntl_wr(req_wr[0]), .cntl_done(cdone[0]),
    .cntl_addr(ca16m), .cntl_din(din16m), .cntl_dout(crdata[0][15:0]),
    .cntl_mask(mk16m), .dbg_state(st_v[0])
  );

  ram_bus_adapter #(.ADDR_W(25), .MEM_W(16), .USE_MASK(1'b0)) u16r (
    .clk(clk), .reset(reset), .en(en[1]), .wr(wr), .size(size), .addr(addr),
    .data_in(data_in), .data_out(dout_v[1]), .wt(wt_v[1]), .err(err_v[1]),
    .cntl_rd(req_rd[1]), .cntl_wr(req_wr[1]), .cntl_done(cdone[1]),
    .cntl_addr(ca16r), .cntl_din(din16r), .cntl_dout(crdata[1][15:0]),
    .cntl_mask(mk16r), .dbg_state(st_v[1])
  );

  ram_bus_adapter #(.ADDR_W(25), .MEM_W(32), .USE_MASK(1'b1)) u32 (
    .clk(clk), .reset(reset), .en(en[2]), .wr(wr), .size(size), .addr(addr),
    .data_in(data_in), .data_out(dout_v[2]), .wt(wt_v[2]), .err(err_v[2]),
    .cntl_rd(req_rd[2]), .cntl_wr(req_wr[2]), .cntl_done(cdone[2]),
    .cntl_addr(ca32), .cntl_din(din32), .cntl_dout(crdata[2]),
    .cntl_mask(mk32), .dbg_state(st_v[2])
  );

  assign req_addr[0] = ca16m;
  assign req_addr[1] = ca16r;
  assign req_addr[2] = {1'b0, ca32};
  assign req_din[0]  = {16'h0, din16m};
  assign req_din[1]  = {16'h0, din16r};
  assign req_din[2]  = din32;
  assign req_mask[0] = {2'b00, mk16m};
  assign req_mask[1] = {2'b00, mk16r};
  assign req_mask[2] = mk32;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input int idx, input logic w, input logic [1:0] s,
                       input logic [24:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = w; size = s; addr = a; data_in = d;
    en[idx] = 1'b1;
  endtask

  // Plays one controller beat: waits for the request, checks it, holds done off
  // for dly cycles, then pulses done with rdata.
  task automatic do_beat(input int idx, input logic is_wr, input logic [23:0] exp_a,
                         input logic [31:0] exp_d, input logic [31:0] dmask,
                         input logic [3:0] exp_m, input logic [31:0] rdata, input int dly);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      seen = req_rd[idx] | req_wr[idx];
    end
    chk("req_seen", {31'h0, seen}, 32'h1);
    if (seen) begin
      chk("req_is_wr", {31'h0, req_wr[idx]}, {31'h0, is_wr});
      chk("req_is_rd", {31'h0, req_rd[idx]}, {31'h0, !is_wr});
      chk("cntl_addr", {8'h0, req_addr[idx]}, {8'h0, exp_a});
      chk("wt_busy", {31'h0, wt_v[idx]}, 32'h1);
      if (is_wr) begin
        chk("cntl_din", req_din[idx] & dmask, exp_d);
        chk("cntl_mask", {28'h0, req_mask[idx]}, {28'h0, exp_m});
      end
    end
    if (dly > 0) begin
      repeat (dly) @(negedge clk);
      #1;
      chk("req_hold", {31'h0, req_rd[idx] | req_wr[idx]}, 32'h1);
      chk("addr_hold", {8'h0, req_addr[idx]}, {8'h0, exp_a});
    end
    crdata[idx] = rdata;
    cdone[idx]  = 1'b1;
    #1;
    chk("req_drop", {31'h0, req_rd[idx] | req_wr[idx]}, 32'h0);
    @(negedge clk);
    cdone[idx]  = 1'b0;
    crdata[idx] = 32'h0;
  endtask

  // Checks the single wt=0 cycle, then that the adapter is idle and busy-high again.
  task automatic end_access(input int idx, input logic exp_err, input logic [31:0] exp_dout);
    #1;
    chk("wt_low", {31'h0, wt_v[idx]}, 32'h0);
    chk("err", {31'h0, err_v[idx]}, {31'h0, exp_err});
    chk("data_out", dout_v[idx], exp_dout);
    en[idx] = 1'b0;
    @(negedge clk); #1;
    chk("wt_back_high", {31'h0, wt_v[idx]}, 32'h1);
    chk("err_cleared", {31'h0, err_v[idx]}, 32'h0);
    chk("state_idle", {29'h0, st_v[idx]}, 32'h0);
    chk("no_req", {31'h0, req_rd[idx] | req_wr[idx]}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; wr = 1'b0; size = 2'b00; addr = '0; data_in = '0;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; cdone[i] = 1'b0; crdata[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_wt", {31'h0, wt_v[i]}, 32'h1);
      chk("rst_err", {31'h0, err_v[i]}, 32'h0);
      chk("rst_dout", dout_v[i], 32'h0);
      chk("rst_rd", {31'h0, req_rd[i]}, 32'h0);
      chk("rst_wr", {31'h0, req_wr[i]}, 32'h0);
      chk("rst_state", {29'h0, st_v[i]}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    // 16-bit: word write split into two beats, big-endian order
    start(0, 1'b1, 2'b10, 25'h100, 32'hDEADBEEF);
    do_beat(0, 1'b1, 24'h80, 32'h0000DEAD, 32'h0000FFFF, 4'b0011, 32'h0, 1);
    do_beat(0, 1'b1, 24'h81, 32'h0000BEEF, 32'h0000FFFF, 4'b0011, 32'h0, 0);
    end_access(0, 1'b0, 32'h0);

    // 16-bit: word read with slow controller
    start(0, 1'b0, 2'b10, 25'h100, 32'h0);
    do_beat(0, 1'b0, 24'h80, 32'h0, 32'h0, 4'h0, 32'h1234, 3);
    do_beat(0, 1'b0, 24'h81, 32'h0, 32'h0, 4'h0, 32'h5678, 3);
    end_access(0, 1'b0, 32'h12345678);

    // Misaligned halfword read: no request, data_out kept
    start(0, 1'b0, 2'b01, 25'h101, 32'h0);
    @(negedge clk); #1;
    chk("mis_no_rd", {31'h0, req_rd[0]}, 32'h0);
    chk("mis_no_wr", {31'h0, req_wr[0]}, 32'h0);
    end_access(0, 1'b1, 32'h12345678);

    // Masked byte write: single beat in the low lane
    start(0, 1'b1, 2'b00, 25'h103, 32'h000000AB);
    do_beat(0, 1'b1, 24'h81, 32'h000000AB, 32'h000000FF, 4'b0001, 32'h0, 1);
    end_access(0, 1'b0, 32'h12345678);

    // Read-modify-write byte write
    start(1, 1'b1, 2'b00, 25'h103, 32'h000000AB);
    do_beat(1, 1'b0, 24'h81, 32'h0, 32'h0, 4'h0, 32'h1122, 1);
    do_beat(1, 1'b1, 24'h81, 32'h000011AB, 32'h0000FFFF, 4'b0011, 32'h0, 0);
    end_access(1, 1'b0, 32'h0);

    // 32-bit: halfword and byte lane selection on read
    start(2, 1'b0, 2'b01, 25'h006, 32'h0);
    do_beat(2, 1'b0, 24'h1, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 2);
    end_access(2, 1'b0, 32'h0000F00D);
    start(2, 1'b0, 2'b00, 25'h005, 32'h0);
    do_beat(2, 1'b0, 24'h1, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 0);
    end_access(2, 1'b0, 32'h000000FE);

    // 32-bit: zero-wait full word write
    start(2, 1'b1, 2'b10, 25'h008, 32'h01020304);
    do_beat(2, 1'b1, 24'h2, 32'h01020304, 32'hFFFFFFFF, 4'b1111, 32'h0, 0);
    end_access(2, 1'b0, 32'h000000FE);

    // Reset between beats of a word write; a late done must be ignored
    start(0, 1'b1, 2'b10, 25'h200, 32'hCAFEBABE);
    do_beat(0, 1'b1, 24'h100, 32'h0000CAFE, 32'h0000FFFF, 4'b0011, 32'h0, 0);
    #1;
    chk("second_beat_up", {31'h0, req_wr[0]}, 32'h1);
    reset = 1'b1;
    en[0] = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_no_wr", {31'h0, req_wr[0]}, 32'h0);
    chk("rst_mid_state", {29'h0, st_v[0]}, 32'h0);
    chk("rst_mid_wt", {31'h0, wt_v[0]}, 32'h1);
    reset = 1'b0;
    cdone[0] = 1'b1;
    @(negedge clk);
    cdone[0] = 1'b0;
    #1;
    chk("late_done_wt", {31'h0, wt_v[0]}, 32'h1);
    chk("late_done_state", {29'h0, st_v[0]}, 32'h0);
    chk("late_done_req", {31'h0, req_rd[0] | req_wr[0]}, 32'h0);
    @(negedge clk); #1;
    chk("late_done_wt2", {31'h0, wt_v[0]}, 32'h1);
    chk("late_done_err", {31'h0, err_v[0]}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
